// File: rtl/idfilt_pkg.sv
// idfilt_pkg: shared types and helpers for the ID acceptance filter bank.
//   - idfiltState_t : collection FSM states (IDLE, COLLECT, COMPARE, DONE)
//   - ID_STD_W_DEF / ID_EXT_W_DEF : default standard / extended ID lengths
//   - lenMaskFn     : ones in the low stdW or extW bits, selected by extMode
package idfilt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } idfiltState_t;

  localparam int ID_STD_W_DEF = 11;
  localparam int ID_EXT_W_DEF = 29;

  // Returns a 64-bit mask; callers truncate it to their own ID width.
  function automatic logic [63:0] lenMaskFn(input logic extMode,
                                            input int   stdW = ID_STD_W_DEF,
                                            input int   extW = ID_EXT_W_DEF);
    int w;
    w = extMode ? extW : stdW;
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/id_filter_bank_if.sv
// id_filter_bank_if: bit-stream input and result bundle of the ID filter bank.
//   master drives : enable, clear, extMode, dIn, samplePulse
//   slave drives  : busy, idCheckComplete, idMatch, matchVec, matchIdx, rxId
interface id_filter_bank_if
  import idfilt_pkg::*;
#(
  parameter int N_FILT   = 4,
  parameter int ID_EXT_W = ID_EXT_W_DEF
);
  localparam int IDXW = (N_FILT > 1) ? $clog2(N_FILT) : 1;

  logic                enable;
  logic                clear;
  logic                extMode;
  logic                dIn;
  logic                samplePulse;
  logic                busy;
  logic                idCheckComplete;
  logic                idMatch;
  logic [N_FILT-1:0]   matchVec;
  logic [IDXW-1:0]     matchIdx;
  logic [ID_EXT_W-1:0] rxId;

  modport master (
    output enable, clear, extMode, dIn, samplePulse,
    input  busy, idCheckComplete, idMatch, matchVec, matchIdx, rxId
  );

  modport slave (
    input  enable, clear, extMode, dIn, samplePulse,
    output busy, idCheckComplete, idMatch, matchVec, matchIdx, rxId
  );
endinterface

// File: rtl/idfilt_match.sv
// idfilt_match: combinational masked compare of one acceptance filter.
//   rxId     in  W : received ID, right-aligned
//   filtId   in  W : filter ID
//   filtMask in  W : 1 = bit must match
//   lenMask  in  W : ones over the active ID length
//   filtEn   in  1 : filter enable
//   hit      out 1 : filter enabled and all masked bits equal
module idfilt_match
  import idfilt_pkg::*;
#(
  parameter int W = ID_EXT_W_DEF
) (
  input  logic [W-1:0] rxId,
  input  logic [W-1:0] filtId,
  input  logic [W-1:0] filtMask,
  input  logic [W-1:0] lenMask,
  input  logic         filtEn,
  output logic         hit
);

  assign hit = filtEn && (((rxId ^ filtId) & filtMask & lenMask) == '0);

endmodule

// File: rtl/id_filter_bank.sv
// id_filter_bank: deserialises the arbitration ID from sampled bus bits and
// checks it against N_FILT masked acceptance filters.
//   clk, resetN        : clock, asynchronous active-low reset
//   bus (slave)        : enable/clear/extMode/dIn/samplePulse in,
//                        busy/idCheckComplete/idMatch/matchVec/matchIdx/rxId out
//   filtId, filtMask   : per-filter ID and care mask (right-aligned)
//   filtEn             : per-filter enable
// Build option: IDFILT_MAJORITY_EN resolves each bit by majority vote over
// its SAMPLES pulses; without it the last sample of the bit is taken.
module id_filter_bank
  import idfilt_pkg::*;
#(
  parameter int N_FILT   = 4,
  parameter int ID_STD_W = ID_STD_W_DEF,
  parameter int ID_EXT_W = ID_EXT_W_DEF,
  parameter int SAMPLES  = 3
) (
  input  logic                           clk,
  input  logic                           resetN,
  id_filter_bank_if.slave                bus,
  input  logic [N_FILT-1:0][ID_EXT_W-1:0] filtId,
  input  logic [N_FILT-1:0][ID_EXT_W-1:0] filtMask,
  input  logic [N_FILT-1:0]              filtEn
);

  localparam int SCW  = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int BCW  = $clog2(ID_EXT_W + 1);
  localparam int IDXW = (N_FILT > 1) ? $clog2(N_FILT) : 1;
`ifdef IDFILT_MAJORITY_EN
  localparam int OCW  = $clog2(SAMPLES + 1);
`endif

  idfiltState_t                    state;
  logic [SCW-1:0]                  sampleCnt;
  logic [BCW-1:0]                  bitCnt;
  logic [ID_EXT_W-1:0]             shiftReg;
  logic                            extSnap;
  logic [N_FILT-1:0][ID_EXT_W-1:0] filtIdSnap;
  logic [N_FILT-1:0][ID_EXT_W-1:0] filtMaskSnap;
  logic [N_FILT-1:0]               filtEnSnap;
`ifdef IDFILT_MAJORITY_EN
  logic [OCW-1:0]                  onesCnt;
  logic [OCW-1:0]                  onesNext;
`endif

  logic                busyR;
  logic                completeR;
  logic                matchR;
  logic [N_FILT-1:0]   vecR;
  logic [IDXW-1:0]     idxR;
  logic [ID_EXT_W-1:0] rxIdR;

  logic                isLastSample;
  logic                resolvedBit;
  logic [BCW-1:0]      bitCntNext;
  logic [BCW-1:0]      frameLen;
  logic                takeSample;
  logic                frameEnd;
  logic [ID_EXT_W-1:0] lenMask;
  logic [N_FILT-1:0]   hitVec;
  logic [IDXW-1:0]     idxNext;

  // Sample bookkeeping shared by IDLE (the starting pulse is sample 1 of
  // bit 0) and COLLECT. In IDLE the counters are zero and the frame length
  // comes straight from extMode because the snapshot is not taken yet.
  always_comb begin
    isLastSample = (sampleCnt == SCW'(SAMPLES - 1));
`ifdef IDFILT_MAJORITY_EN
    onesNext     = onesCnt + OCW'(bus.dIn);
    resolvedBit  = (onesNext >= OCW'((SAMPLES + 1) / 2));
`else
    resolvedBit  = bus.dIn;
`endif
    bitCntNext   = bitCnt + BCW'(1);
    frameLen     = ((state == IDLE) ? bus.extMode : extSnap) ? BCW'(ID_EXT_W) : BCW'(ID_STD_W);
    takeSample   = bus.enable && bus.samplePulse && ((state == IDLE) || (state == COLLECT));
    frameEnd     = takeSample && isLastSample && (bitCntNext == frameLen);
  end

  assign lenMask = ID_EXT_W'(lenMaskFn(extSnap, ID_STD_W, ID_EXT_W));

  // One masked comparator per filter, all fed from the snapshotted settings.
  for (genvar g = 0; g < N_FILT; g++) begin : gFilt
    idfilt_match #(.W(ID_EXT_W)) uMatch (
      .rxId    (shiftReg),
      .filtId  (filtIdSnap[g]),
      .filtMask(filtMaskSnap[g]),
      .lenMask (lenMask),
      .filtEn  (filtEnSnap[g]),
      .hit     (hitVec[g])
    );
  end

  // Lowest matching filter wins; scanning downward leaves the lowest index.
  always_comb begin
    idxNext = '0;
    for (int i = N_FILT - 1; i >= 0; i--) begin
      if (hitVec[i]) idxNext = IDXW'(i);
    end
  end

  // Frame FSM. Priority is reset, then clear, then an enable drop during
  // collection (which discards the partial frame), then normal operation.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      sampleCnt    <= '0;
      bitCnt       <= '0;
      shiftReg     <= '0;
      extSnap      <= 1'b0;
      filtIdSnap   <= '0;
      filtMaskSnap <= '0;
      filtEnSnap   <= '0;
`ifdef IDFILT_MAJORITY_EN
      onesCnt      <= '0;
`endif
      busyR        <= 1'b0;
      completeR    <= 1'b0;
      matchR       <= 1'b0;
      vecR         <= '0;
      idxR         <= '0;
      rxIdR        <= '0;
    end else if (bus.clear) begin
      state     <= IDLE;
      sampleCnt <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
`ifdef IDFILT_MAJORITY_EN
      onesCnt   <= '0;
`endif
      busyR     <= 1'b0;
      completeR <= 1'b0;
      matchR    <= 1'b0;
      vecR      <= '0;
      idxR      <= '0;
      rxIdR     <= '0;
    end else if ((state == COLLECT) && !bus.enable) begin
      state     <= IDLE;
      sampleCnt <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
`ifdef IDFILT_MAJORITY_EN
      onesCnt   <= '0;
`endif
      busyR     <= 1'b0;
    end else begin
      if (takeSample) begin
        if (isLastSample) begin
          shiftReg  <= {shiftReg[ID_EXT_W-2:0], resolvedBit};
          bitCnt    <= bitCntNext;
          sampleCnt <= '0;
`ifdef IDFILT_MAJORITY_EN
          onesCnt   <= '0;
`endif
        end else begin
          sampleCnt <= sampleCnt + SCW'(1);
`ifdef IDFILT_MAJORITY_EN
          onesCnt   <= onesNext;
`endif
        end
      end

      case (state)
        IDLE: begin
          if (takeSample) begin
            extSnap      <= bus.extMode;
            filtIdSnap   <= filtId;
            filtMaskSnap <= filtMask;
            filtEnSnap   <= filtEn;
            busyR        <= 1'b1;
            state        <= frameEnd ? COMPARE : COLLECT;
          end
        end
        COLLECT: begin
          if (frameEnd) state <= COMPARE;
        end
        COMPARE: begin
          matchR    <= |hitVec;
          vecR      <= hitVec;
          idxR      <= idxNext;
          rxIdR     <= shiftReg & lenMask;
          completeR <= 1'b1;
          busyR     <= 1'b0;
          bitCnt    <= '0;
          state     <= DONE;
        end
        DONE: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy            = busyR;
  assign bus.idCheckComplete = completeR;
  assign bus.idMatch         = matchR;
  assign bus.matchVec        = vecR;
  assign bus.matchIdx        = idxR;
  assign bus.rxId            = rxIdR;

endmodule

// File: tb/tb_id_filter_bank.sv
// tb_id_filter_bank: directed plus randomized frames against a behavioural
// model of ID reception and masked filtering. Honours IDFILT_MAJORITY_EN.
module tb_id_filter_bank;

  localparam int NF = 4;
  localparam int EW = 29;
  localparam int SW = 11;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  id_filter_bank_if #(.N_FILT(NF), .ID_EXT_W(EW)) bus ();

  logic [NF-1:0][EW-1:0] filtId;
  logic [NF-1:0][EW-1:0] filtMask;
  logic [NF-1:0]         filtEn;

  id_filter_bank #(.N_FILT(NF), .ID_STD_W(SW), .ID_EXT_W(EW), .SAMPLES(3)) dut (
    .clk     (clk),
    .resetN  (resetN),
    .bus     (bus),
    .filtId  (filtId),
    .filtMask(filtMask),
    .filtEn  (filtEn)
  );

  int vectorCount = 0;
  int failCount   = 0;

  // patTable[b][s] is the level presented on sample pulse s of bit b.
  logic [2:0]  patTable [0:28];
  logic [63:0] snapId   [NF];
  logic [63:0] snapMask [NF];
  logic        snapEn   [NF];
  logic        snapExt;
  logic [63:0] modelId;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic resolveBit(input logic [2:0] p);
`ifdef IDFILT_MAJORITY_EN
    int ones;
    ones = int'(p[0]) + int'(p[1]) + int'(p[2]);
    return (ones >= 2);
`else
    return p[2];
`endif
  endfunction

  task automatic fillClean(input logic [63:0] id, input int n);
    for (int b = 0; b < n; b++) patTable[b] = id[n-1-b] ? 3'b111 : 3'b000;
  endtask

  task automatic fillNoisy(input logic [63:0] id, input int n);
    fillClean(id, n);
    for (int b = 0; b < n; b++) if ($urandom_range(2, 0) == 0) patTable[b] = 3'($urandom);
  endtask

  task automatic captureSnapshot;
    for (int i = 0; i < NF; i++) begin
      snapId[i]   = 64'(filtId[i]);
      snapMask[i] = 64'(filtMask[i]);
      snapEn[i]   = filtEn[i];
    end
    snapExt = bus.extMode;
  endtask

  task automatic scrambleFilters;
    for (int i = 0; i < NF; i++) begin
      filtId[i]   = EW'($urandom);
      filtMask[i] = EW'($urandom);
    end
    filtEn      = NF'($urandom);
    bus.extMode = 1'($urandom);
  endtask

  task automatic randomFilters(input logic [63:0] likelyId);
    for (int i = 0; i < NF; i++) begin
      filtEn[i] = 1'($urandom);
      case ($urandom_range(2, 0))
        0:       filtMask[i] = {EW{1'b1}};
        1:       filtMask[i] = '0;
        default: filtMask[i] = EW'($urandom);
      endcase
      filtId[i] = ($urandom_range(1, 0) == 1) ? EW'(likelyId) : EW'($urandom);
    end
  endtask

  // Sends nBits bits from patTable with up to maxGap idle cycles between
  // pulses; returns the ID the model says the receiver must assemble.
  task automatic applyStimulus(input int nBits, input int maxGap, input bit scramble,
                               output logic [63:0] expId);
    logic [2:0] p;
    expId = '0;
    for (int b = 0; b < nBits; b++) begin
      p = patTable[b];
      for (int s = 0; s < 3; s++) begin
        bus.dIn         = p[s];
        bus.samplePulse = 1'b1;
        tick();
        bus.samplePulse = 1'b0;
        if (b == 0 && s == 0) begin
          checkOutput("startBusy", 64'(bus.busy), 64'd1);
          if (scramble) scrambleFilters();
        end
        if (!(b == nBits - 1 && s == 2)) repeat ($urandom_range(maxGap, 0)) tick();
      end
      expId = (expId << 1) | 64'(resolveBit(p));
    end
  endtask

  // Called one cycle after the final pulse: COMPARE now, result next cycle.
  task automatic finishFrame(input string tag, input logic [63:0] expId);
    logic [63:0] lm;
    logic [63:0] expVec;
    logic [63:0] expIdx;
    bit          found;
    checkOutput({tag, ".cmpNotDone"}, 64'(bus.idCheckComplete), 64'd0);
    checkOutput({tag, ".cmpBusy"}, 64'(bus.busy), 64'd1);
    tick();
    checkOutput({tag, ".complete"}, 64'(bus.idCheckComplete), 64'd1);
    checkOutput({tag, ".doneBusy"}, 64'(bus.busy), 64'd0);
    lm     = snapExt ? ((64'd1 << EW) - 64'd1) : ((64'd1 << SW) - 64'd1);
    expVec = '0;
    expIdx = '0;
    found  = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (snapEn[i] && (((expId ^ snapId[i]) & snapMask[i] & lm) == 64'd0)) begin
        expVec[i] = 1'b1;
        if (!found) begin
          expIdx = 64'(i);
          found  = 1'b1;
        end
      end
    end
    checkOutput({tag, ".rxId"}, 64'(bus.rxId), expId);
    checkOutput({tag, ".matchVec"}, 64'(bus.matchVec), expVec);
    checkOutput({tag, ".matchIdx"}, 64'(bus.matchIdx), expIdx);
    checkOutput({tag, ".idMatch"}, 64'(bus.idMatch), 64'(found));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".busy"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, ".complete"}, 64'(bus.idCheckComplete), 64'd0);
    checkOutput({tag, ".idMatch"}, 64'(bus.idMatch), 64'd0);
    checkOutput({tag, ".matchVec"}, 64'(bus.matchVec), 64'd0);
    checkOutput({tag, ".matchIdx"}, 64'(bus.matchIdx), 64'd0);
    checkOutput({tag, ".rxId"}, 64'(bus.rxId), 64'd0);
  endtask

  task automatic doClear;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    checkAllZero("clear");
  endtask

  initial begin
    bus.enable      = 1'b0;
    bus.clear       = 1'b0;
    bus.extMode     = 1'b0;
    bus.dIn         = 1'b0;
    bus.samplePulse = 1'b0;
    filtId          = '0;
    filtMask        = '0;
    filtEn          = '0;

    // Reset state
    repeat (2) tick();
    checkAllZero("reset");
    resetN = 1'b1;
    tick();

    // A start pulse coincident with clear must not open a frame
    bus.enable      = 1'b1;
    bus.samplePulse = 1'b1;
    bus.clear       = 1'b1;
    tick();
    bus.samplePulse = 1'b0;
    bus.clear       = 1'b0;
    checkOutput("clearPulseBusy", 64'(bus.busy), 64'd0);
    tick();
    checkOutput("clearPulseIdle", 64'(bus.busy), 64'd0);

    // Standard ID 0x123, clean back-to-back pulses, filter0 exact
    filtId[0]   = EW'(29'h123);
    filtMask[0] = {EW{1'b1}};
    filtEn      = 4'b0001;
    bus.extMode = 1'b0;
    captureSnapshot();
    fillClean(64'h123, SW);
    applyStimulus(SW, 0, 1'b0, modelId);
    finishFrame("std123", modelId);
    checkOutput("std123.rxIdConst", 64'(bus.rxId), 64'h123);
    checkOutput("std123.vecConst", 64'(bus.matchVec), 64'h1);
    checkOutput("std123.idxConst", 64'(bus.matchIdx), 64'h0);

    // In DONE: filter changes and pulses must not disturb the result
    filtId[0] = EW'(29'h0);
    filtEn    = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      bus.dIn         = 1'($urandom);
      bus.samplePulse = 1'b1;
      tick();
    end
    bus.samplePulse = 1'b0;
    checkOutput("hold.complete", 64'(bus.idCheckComplete), 64'd1);
    checkOutput("hold.rxId", 64'(bus.rxId), 64'h123);
    checkOutput("hold.vec", 64'(bus.matchVec), 64'h1);
    checkOutput("hold.idMatch", 64'(bus.idMatch), 64'd1);
    checkOutput("hold.busy", 64'(bus.busy), 64'd0);
    doClear();

    // Extended ID, filter2 ignores bit 0, filter0 exact but disabled
    filtId      = '0;
    filtMask    = '0;
    filtId[0]   = EW'(29'h1ABCDE01);
    filtMask[0] = {EW{1'b1}};
    filtId[2]   = EW'(29'h1ABCDE00);
    filtMask[2] = EW'(29'h1FFFFFFE);
    filtEn      = 4'b0100;
    bus.extMode = 1'b1;
    captureSnapshot();
    fillClean(64'h1ABCDE01, EW);
    applyStimulus(EW, 2, 1'b0, modelId);
    finishFrame("ext", modelId);
    checkOutput("ext.rxIdConst", 64'(bus.rxId), 64'h1ABCDE01);
    checkOutput("ext.vecConst", 64'(bus.matchVec), 64'h4);
    checkOutput("ext.idxConst", 64'(bus.matchIdx), 64'h2);
    doClear();

    // Split-sample bits: 1,0,1 / 0,1,0 / 1,1,0 (samples in pulse order)
    bus.extMode = 1'b0;
    fillClean(64'($urandom_range(2047, 0)), SW);
    patTable[0] = 3'b101;
    patTable[4] = 3'b010;
    patTable[7] = 3'b011;
    filtId      = '0;
    filtMask    = '0;
    filtId[1]   = EW'($urandom);
    filtMask[1] = {EW{1'b1}};
    filtEn      = 4'b1010;
    captureSnapshot();
    applyStimulus(SW, 1, 1'b0, modelId);
    finishFrame("vote", modelId);
    checkOutput("vote.bit0", 64'(bus.rxId[10]), 64'd1);
    checkOutput("vote.bit4", 64'(bus.rxId[6]), 64'd0);
`ifdef IDFILT_MAJORITY_EN
    checkOutput("vote.bit7", 64'(bus.rxId[3]), 64'd1);
`else
    checkOutput("vote.bit7", 64'(bus.rxId[3]), 64'd0);
`endif
    checkOutput("vote.zeroMaskHit", 64'(bus.matchVec[3]), 64'd1);
    doClear();

    // Abort after 6 bits, then a full frame carrying 0x7FF
    filtId      = '0;
    filtMask    = '0;
    filtId[0]   = EW'(29'h2AA);
    filtMask[0] = {EW{1'b1}};
    filtId[1]   = EW'(29'h7FF);
    filtMask[1] = {EW{1'b1}};
    filtEn      = 4'b0011;
    fillClean(64'h2AA, SW);
    applyStimulus(6, 1, 1'b0, modelId);
    bus.enable = 1'b0;
    tick();
    checkOutput("abort.busy", 64'(bus.busy), 64'd0);
    checkOutput("abort.complete", 64'(bus.idCheckComplete), 64'd0);
    tick();
    bus.enable = 1'b1;
    captureSnapshot();
    fillClean(64'h7FF, SW);
    applyStimulus(SW, 1, 1'b0, modelId);
    finishFrame("restart", modelId);
    checkOutput("restart.rxIdConst", 64'(bus.rxId), 64'h7FF);
    checkOutput("restart.vecConst", 64'(bus.matchVec), 64'h2);
    checkOutput("restart.idxConst", 64'(bus.matchIdx), 64'h1);
    doClear();

    // Asynchronous reset in the middle of collection
    fillClean(64'($urandom_range(2047, 0)), SW);
    applyStimulus(5, 1, 1'b0, modelId);
    checkOutput("preReset.busy", 64'(bus.busy), 64'd1);
    #2;
    resetN = 1'b0;
    #1;
    checkAllZero("asyncReset");
    tick();
    #2;
    resetN = 1'b1;
    tick();
    bus.extMode = 1'b1;
    modelId     = 64'($urandom) & 64'h1FFFFFFF;
    randomFilters(modelId);
    captureSnapshot();
    fillClean(modelId, EW);
    applyStimulus(EW, 1, 1'b0, modelId);
    finishFrame("postReset", modelId);
    doClear();

    // Randomized frames; frame 0 has every filter disabled
    for (int f = 0; f < 8; f++) begin
      logic [63:0] seedId;
      int          nBits;
      bus.extMode = 1'($urandom);
      nBits       = bus.extMode ? EW : SW;
      seedId      = 64'($urandom) & ((64'd1 << nBits) - 64'd1);
      randomFilters(seedId);
      if (f == 0) filtEn = '0;
      captureSnapshot();
      if (f % 2 == 1) fillNoisy(seedId, nBits);
      else            fillClean(seedId, nBits);
      applyStimulus(nBits, 2, 1'($urandom), modelId);
      finishFrame($sformatf("rand%0d", f), modelId);
      doClear();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
